// File: rtl/fft_r4_stage_ctrl.sv
// Radix-4 DIF FFT stage sequencer.
// Walks every radix-4 stage, issues one butterfly (four read addresses plus twiddle
// exponent) per clock, and replays the same addresses as write-backs RD_LAT+1 cycles later.
// Optional stall input iHOLD is present only when FFT_R4_CTRL_HOLD_EN is defined.
// Requires N_LOG4 >= 2 and RD_LAT >= 1.

module fft_r4_stage_ctrl #(
  parameter int unsigned N_LOG4 = 4,
  parameter int unsigned RD_LAT = 1,
  localparam int unsigned ADDR_W  = 2 * N_LOG4,
  localparam int unsigned TW_W    = ADDR_W - 2,
  localparam int unsigned STAGE_W = (N_LOG4 > 1) ? $clog2(N_LOG4) : 1
) (
  input  logic               iCLK,
  input  logic               iRESET,
`ifdef FFT_R4_CTRL_HOLD_EN
  input  logic               iHOLD,
`endif
  input  logic               iSTART,
  output logic               oBUSY,
  output logic               oDONE,
  output logic [STAGE_W-1:0] oSTAGE,
  output logic               oRD_EN,
  output logic [ADDR_W-1:0]  oRD_ADDR0,
  output logic [ADDR_W-1:0]  oRD_ADDR1,
  output logic [ADDR_W-1:0]  oRD_ADDR2,
  output logic [ADDR_W-1:0]  oRD_ADDR3,
  output logic [TW_W-1:0]    oTW_EXP,
  output logic               oWR_EN,
  output logic [ADDR_W-1:0]  oWR_ADDR0,
  output logic [ADDR_W-1:0]  oWR_ADDR1,
  output logic [ADDR_W-1:0]  oWR_ADDR2,
  output logic [ADDR_W-1:0]  oWR_ADDR3
);

  localparam int unsigned BFLY_W = ADDR_W - 2;
  localparam int unsigned DCNT_W = $clog2(RD_LAT + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StFin} state_e;

  logic hold;
`ifdef FFT_R4_CTRL_HOLD_EN
  assign hold = iHOLD;
`else
  assign hold = 1'b0;
`endif

  state_e              state_q, state_d;
  logic [STAGE_W-1:0]  stage_q, stage_d;
  logic [BFLY_W-1:0]   b_q, b_d;
  logic [DCNT_W-1:0]   dcnt_q, dcnt_d;

  // Output registers are loaded from next-state values so they line up with state_q.
  logic                    busy_q, busy_d;
  logic                    done_q, done_d;
  logic                    rd_en_q, rd_en_d;
  logic [3:0][ADDR_W-1:0]  rd_addr_q, rd_addr_d;
  logic [TW_W-1:0]         tw_q, tw_d;

  logic [RD_LAT:0]         pipe_en_q;
  logic [3:0][ADDR_W-1:0]  pipe_addr_q [RD_LAT+1];
  logic                    wr_en_q;
  logic [3:0][ADDR_W-1:0]  wr_addr_q;

  int unsigned             sh;
  logic [ADDR_W-1:0]       b_ext, mask, pos, base;
  logic [3:0][ADDR_W-1:0]  addr_calc;
  logic [TW_W-1:0]         tw_calc;

  // State and counter registers.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      state_q <= StIdle;
      stage_q <= '0;
      b_q     <= '0;
      dcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      b_q     <= b_d;
      dcnt_q  <= dcnt_d;
    end
  end

  // Next-state and counter update; everything freezes while held.
  always_comb begin
    state_d = state_q;
    stage_d = stage_q;
    b_d     = b_q;
    dcnt_d  = dcnt_q;
    if (!hold) begin
      unique case (state_q)
        StIdle: begin
          if (iSTART) begin
            state_d = StRun;
            stage_d = '0;
            b_d     = '0;
          end
        end
        StRun: begin
          b_d = b_q + 1'b1;
          if (b_q == '1) begin
            state_d = StDrain;
            dcnt_d  = '0;
          end
        end
        StDrain: begin
          dcnt_d = dcnt_q + 1'b1;
          // The last DRAIN cycle carries the stage's final write-back.
          if (dcnt_q == DCNT_W'(RD_LAT)) begin
            if (stage_q == STAGE_W'(N_LOG4 - 1)) begin
              state_d = StFin;
            end else begin
              state_d = StRun;
              stage_d = stage_q + 1'b1;
              b_d     = '0;
            end
          end
        end
        StFin:   state_d = StIdle;
        default: state_d = StIdle;
      endcase
    end
  end

  // Address/twiddle generation and next values of the registered outputs.
  always_comb begin
    sh    = 2 * (N_LOG4 - 1 - 32'(stage_d));
    b_ext = {2'b00, b_d};
    mask  = (ADDR_W'(1) << sh) - ADDR_W'(1);
    pos   = b_ext & mask;
    // grp*4*span + pos, with grp = b >> sh
    base  = ((b_ext >> sh) << (sh + 2)) | pos;
    for (int k = 0; k < 4; k++) begin
      addr_calc[k] = base | (ADDR_W'(k) << sh);
    end
    tw_calc   = TW_W'(pos << (2 * 32'(stage_d)));

    rd_en_d   = (state_d == StRun) && !hold;
    rd_addr_d = rd_en_d ? addr_calc : rd_addr_q;
    tw_d      = rd_en_d ? tw_calc : tw_q;
    busy_d    = (state_d != StIdle);
    done_d    = (state_d == StFin) && (state_q != StFin);
  end

  // Read-side output registers.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      tw_q      <= '0;
    end else begin
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      tw_q      <= tw_d;
    end
  end

  // Write-back pipeline: stage 0 mirrors the read outputs, write output trails by RD_LAT+1.
  always_ff @(posedge iCLK or negedge iRESET) begin
    if (!iRESET) begin
      pipe_en_q <= '0;
      for (int i = 0; i <= RD_LAT; i++) begin
        pipe_addr_q[i] <= '0;
      end
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
    end else if (hold) begin
      wr_en_q <= 1'b0;
    end else begin
      pipe_en_q      <= {pipe_en_q[RD_LAT-1:0], rd_en_d};
      pipe_addr_q[0] <= rd_addr_d;
      for (int i = 1; i <= RD_LAT; i++) begin
        pipe_addr_q[i] <= pipe_addr_q[i-1];
      end
      wr_en_q   <= pipe_en_q[RD_LAT];
      wr_addr_q <= pipe_addr_q[RD_LAT];
    end
  end

  assign oBUSY     = busy_q;
  assign oDONE     = done_q;
  assign oSTAGE    = stage_q;
  assign oRD_EN    = rd_en_q;
  assign oRD_ADDR0 = rd_addr_q[0];
  assign oRD_ADDR1 = rd_addr_q[1];
  assign oRD_ADDR2 = rd_addr_q[2];
  assign oRD_ADDR3 = rd_addr_q[3];
  assign oTW_EXP   = tw_q;
  assign oWR_EN    = wr_en_q;
  assign oWR_ADDR0 = wr_addr_q[0];
  assign oWR_ADDR1 = wr_addr_q[1];
  assign oWR_ADDR2 = wr_addr_q[2];
  assign oWR_ADDR3 = wr_addr_q[3];

endmodule
